// File: rtl/stream_pkg.sv
// Shared definitions for the stream demultiplexer: select encoding,
// default widths and the one-entry slot state encoding.
package stream_pkg;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_CNT_W = 8;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_e;

endpackage

// File: rtl/stream_slot.sv
// One-entry output register stage with valid/ready handshake and a
// modulo delivered-beat counter; instantiated once per output port.
module stream_slot
    import stream_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] count,
    output logic             can_load
);

    slot_state_e      state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             drain;

    assign drain     = (state_q == FULL) && out_ready;
    // A FULL slot can take a new beat only in the cycle it is drained.
    assign can_load  = (state_q == EMPTY) || out_ready;
    assign out_valid = (state_q == FULL);
    assign out_data  = data_q;
    assign count     = count_q;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        count_d = count_q;
        if (drain) begin
            state_d = EMPTY;
            count_d = count_q + CNT_W'(1);
        end
        if (load && can_load) begin
            state_d = FULL;
            data_d  = load_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            data_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/stream_demux.sv
// Registered 1-to-2 stream demultiplexer: each accepted beat is steered by
// in_sel into the port A or port B slot; head-of-line blocking on stall.
module stream_demux
    import stream_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] a_data,
    output logic             a_valid,
    input  logic             a_ready,
    output logic [WIDTH-1:0] b_data,
    output logic             b_valid,
    input  logic             b_ready,
    output logic [CNT_W-1:0] a_count,
    output logic [CNT_W-1:0] b_count
);

    logic a_can_load, b_can_load;
    logic a_load, b_load;
    logic accept;

    // Readiness follows only the selected slot, so a stalled target blocks
    // the stream even when the other slot is free.
    assign in_ready = (in_sel == SEL_B) ? b_can_load : a_can_load;
    assign accept   = in_valid && in_ready;
    assign a_load   = accept && (in_sel == SEL_A);
    assign b_load   = accept && (in_sel == SEL_B);

    stream_slot #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_slot_a (
        .clk       (clk),
        .rst       (rst),
        .load      (a_load),
        .load_data (in_data),
        .out_ready (a_ready),
        .out_valid (a_valid),
        .out_data  (a_data),
        .count     (a_count),
        .can_load  (a_can_load)
    );

    stream_slot #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_slot_b (
        .clk       (clk),
        .rst       (rst),
        .load      (b_load),
        .load_data (in_data),
        .out_ready (b_ready),
        .out_valid (b_valid),
        .out_data  (b_data),
        .count     (b_count),
        .can_load  (b_can_load)
    );

endmodule

// File: tb/tb_stream_demux.sv
// Self-checking bench for stream_demux: scenario tasks plus a randomized run,
// all checked against a queue-based model of the two output slots.
module tb_stream_demux;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in_data;
    logic       in_sel;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a_data, b_data;
    logic       a_valid, b_valid;
    logic       a_ready, b_ready;
    logic [7:0] a_count, b_count;

    int n_cmp = 0;
    int n_err = 0;

    // Model: each port buffers at most one beat; its queue holds that beat.
    logic [7:0] qa[$];
    logic [7:0] qb[$];
    logic [7:0] last_a, last_b;
    int         cnt_a, cnt_b;

    stream_demux #(.WIDTH(8), .CNT_W(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_sel   (in_sel),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a_data   (a_data),
        .a_valid  (a_valid),
        .a_ready  (a_ready),
        .b_data   (b_data),
        .b_valid  (b_valid),
        .b_ready  (b_ready),
        .a_count  (a_count),
        .b_count  (b_count)
    );

    always #5 clk = ~clk;

    function automatic logic model_ready();
        if (in_sel) return (qb.size() == 0) || b_ready;
        return (qa.size() == 0) || a_ready;
    endfunction

    task automatic drive(input logic r, input logic v, input logic s,
                         input logic [7:0] d, input logic ar, input logic br);
        rst = r; in_valid = v; in_sel = s; in_data = d;
        a_ready = ar; b_ready = br;
        #1;
    endtask

    // Apply the cycle's handshakes to the model, then cross the clock edge.
    task automatic advance();
        logic da, db, acc;
        da  = (qa.size() != 0) && a_ready;
        db  = (qb.size() != 0) && b_ready;
        acc = in_valid && model_ready();
        if (rst) begin
            qa.delete(); qb.delete();
            cnt_a = 0; cnt_b = 0;
            last_a = 8'h00; last_b = 8'h00;
        end else begin
            if (da) begin void'(qa.pop_front()); cnt_a = (cnt_a + 1) % 256; end
            if (db) begin void'(qb.pop_front()); cnt_b = (cnt_b + 1) % 256; end
            if (acc) begin
                if (in_sel) begin qb.push_back(in_data); last_b = in_data; end
                else        begin qa.push_back(in_data); last_a = in_data; end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        advance();
        advance();
        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        advance();
        n_cmp++;
        if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready_during: got %b want 1", in_ready); end
        advance();
        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        n_cmp++;
        if ({a_valid, b_valid} !== 2'b00) begin n_err++; $display("FAIL reset_valid: got %b want 00", {a_valid, b_valid}); end
        n_cmp++;
        if ({a_count, b_count} !== 16'h0000) begin n_err++; $display("FAIL reset_count: got %h want 0000", {a_count, b_count}); end
        n_cmp++;
        if ({a_data, b_data} !== 16'h0000) begin n_err++; $display("FAIL reset_data: got %h want 0000", {a_data, b_data}); end
        n_cmp++;
        if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready_idle: got %b want 1", in_ready); end
    endtask

    task automatic test_steering();
        drive(1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1);
        n_cmp++;
        if (in_ready !== 1'b1) begin n_err++; $display("FAIL steer_ready_a: got %b want 1", in_ready); end
        advance();
        n_cmp++;
        if (a_valid !== 1'b1 || a_data !== 8'h00 || b_valid !== 1'b0) begin
            n_err++; $display("FAIL steer_a: got v=%b d=%h bv=%b want v=1 d=00 bv=0", a_valid, a_data, b_valid);
        end
        drive(1'b0, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b1);
        advance();
        n_cmp++;
        if (b_valid !== 1'b1 || b_data !== 8'hFF || a_valid !== 1'b0) begin
            n_err++; $display("FAIL steer_b: got v=%b d=%h av=%b want v=1 d=ff av=0", b_valid, b_data, a_valid);
        end
        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        advance();
        n_cmp++;
        if (a_count !== 8'd1 || b_count !== 8'd1) begin
            n_err++; $display("FAIL steer_counts: got a=%0d b=%0d want a=1 b=1", a_count, b_count);
        end
    endtask

    task automatic test_backpressure();
        int a0;
        a0 = cnt_a;
        drive(1'b0, 1'b1, 1'b0, 8'h11, 1'b0, 1'b1);
        n_cmp++;
        if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_first_accept: got %b want 1", in_ready); end
        advance();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 1'b0, 8'h22, 1'b0, 1'b1);
            n_cmp++;
            if (in_ready !== 1'b0 || a_data !== 8'h11 || a_valid !== 1'b1) begin
                n_err++; $display("FAIL bp_stall: got rdy=%b d=%h v=%b want rdy=0 d=11 v=1", in_ready, a_data, a_valid);
            end
            advance();
        end
        // Head-of-line: other slot free, but readiness tracks the selected one.
        drive(1'b0, 1'b0, 1'b1, 8'h22, 1'b0, 1'b1);
        n_cmp++;
        if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_sel_b_ready: got %b want 1", in_ready); end
        drive(1'b0, 1'b1, 1'b0, 8'h22, 1'b1, 1'b1);
        n_cmp++;
        if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_drain_refill_ready: got %b want 1", in_ready); end
        advance();
        n_cmp++;
        if (a_valid !== 1'b1 || a_data !== 8'h22 || a_count !== 8'(a0 + 1)) begin
            n_err++; $display("FAIL bp_refill: got v=%b d=%h cnt=%0d want v=1 d=22 cnt=%0d", a_valid, a_data, a_count, a0 + 1);
        end
        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        advance();
        n_cmp++;
        if (a_valid !== 1'b0 || a_count !== 8'(a0 + 2)) begin
            n_err++; $display("FAIL bp_final_drain: got v=%b cnt=%0d want v=0 cnt=%0d", a_valid, a_count, a0 + 2);
        end
    endtask

    task automatic test_throughput();
        do_reset();
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 1'b1, 1'(i % 2), 8'(i), 1'b1, 1'b1);
            n_cmp++;
            if (in_ready !== 1'b1) begin n_err++; $display("FAIL tp_ready beat %0d: got %b want 1", i, in_ready); end
            if (a_valid && qa.size() != 0) begin
                n_cmp++;
                if (a_data !== qa[0]) begin n_err++; $display("FAIL tp_order_a: got %h want %h", a_data, qa[0]); end
            end
            if (b_valid && qb.size() != 0) begin
                n_cmp++;
                if (b_data !== qb[0]) begin n_err++; $display("FAIL tp_order_b: got %h want %h", b_data, qb[0]); end
            end
            advance();
        end
        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        advance();
        advance();
        n_cmp++;
        if (a_count !== 8'd8 || b_count !== 8'd8) begin
            n_err++; $display("FAIL tp_counts: got a=%0d b=%0d want a=8 b=8", a_count, b_count);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 256; i++) begin
            drive(1'b0, 1'b1, 1'b1, 8'(i * 7), 1'b1, 1'b1);
            advance();
            if (i == 255) begin
                n_cmp++;
                if (b_count !== 8'd255) begin n_err++; $display("FAIL wrap_pre: got %0d want 255", b_count); end
            end
        end
        drive(1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b1);
        advance();
        n_cmp++;
        if (b_count !== 8'h00 || a_count !== 8'h00) begin
            n_err++; $display("FAIL wrap: got b=%h a=%h want b=00 a=00", b_count, a_count);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 1'b0, 8'(8'h30 + i), 1'b1, 1'b0);
            advance();
        end
        drive(1'b0, 1'b1, 1'b0, 8'hAA, 1'b1, 1'b0);
        advance();
        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        n_cmp++;
        if (a_valid !== 1'b1 || a_data !== 8'hAA || a_count !== 8'd3) begin
            n_err++; $display("FAIL rm_setup: got v=%b d=%h cnt=%0d want v=1 d=aa cnt=3", a_valid, a_data, a_count);
        end
        drive(1'b1, 1'b1, 1'b0, 8'h55, 1'b1, 1'b0);
        advance();
        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        n_cmp++;
        if (a_valid !== 1'b0 || a_count !== 8'd0) begin
            n_err++; $display("FAIL rm_after_reset: got v=%b cnt=%0d want v=0 cnt=0", a_valid, a_count);
        end
        advance();
        advance();
        n_cmp++;
        if (a_valid !== 1'b0 || a_count !== 8'd0 || b_count !== 8'd0) begin
            n_err++; $display("FAIL rm_no_delivery: got v=%b a=%0d b=%0d want v=0 a=0 b=0", a_valid, a_count, b_count);
        end
    endtask

    task automatic test_random();
        logic       hold, s, v;
        logic [7:0] d;
        do_reset();
        hold = 1'b0; s = 1'b0; d = 8'h00;
        for (int i = 0; i < 400; i++) begin
            if (!hold) begin
                s = 1'($urandom_range(0, 1));
                d = 8'($urandom);
            end
            v = hold ? 1'b1 : ($urandom_range(0, 3) != 0);
            drive(1'b0, v, s, d, ($urandom_range(0, 2) != 0), ($urandom_range(0, 2) != 0));
            n_cmp++;
            if (in_ready !== model_ready()) begin
                n_err++; $display("FAIL rnd_ready cyc %0d: got %b want %b", i, in_ready, model_ready());
            end
            hold = v && !model_ready();
            advance();
            n_cmp++;
            if (a_valid !== (qa.size() != 0) || b_valid !== (qb.size() != 0)
                || a_data !== last_a || b_data !== last_b) begin
                n_err++;
                $display("FAIL rnd_slots cyc %0d: got av=%b ad=%h bv=%b bd=%h want av=%b ad=%h bv=%b bd=%h",
                         i, a_valid, a_data, b_valid, b_data, qa.size() != 0, last_a, qb.size() != 0, last_b);
            end
            n_cmp++;
            if (a_count !== cnt_a[7:0] || b_count !== cnt_b[7:0]) begin
                n_err++; $display("FAIL rnd_counts cyc %0d: got a=%0d b=%0d want a=%0d b=%0d",
                                  i, a_count, b_count, cnt_a, cnt_b);
            end
        end
    endtask

    initial begin
        cnt_a = 0; cnt_b = 0;
        last_a = 8'h00; last_b = 8'h00;
        drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        test_reset();
        test_steering();
        test_backpressure();
        test_throughput();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
